// File: rtl/cost_pkg.sv
// Shared fixed-point helpers for the cost-term datapath.
//   one(width,int_bits) : encoding of 1.0 for the given fixed-point format
//   sat_max/sat_min     : two's complement limits of a width-bit word
//   err_width(width,z)  : width of the per-sample L1 error sum
package cost_pkg;

  function automatic int one(input int width, input int int_bits);
    return 1 << (width - int_bits - 1);
  endfunction

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  function automatic int err_width(input int width, input int z);
    return width + $clog2(z);
  endfunction

endpackage

// File: rtl/cost_stream_if.sv
// Stream bundle between the last forward layer, the cost stage and the
// backprop delta path.
//   in_valid/in_ready/a/y            : input beat (p lanes of activations + ideal bits)
//   out_valid/out_ready/c/out_last   : output beat of saturated cost terms
//   err_sum                          : sample L1 error, meaningful with out_valid && out_last
// master = producer/consumer side (drives inputs, accepts outputs); slave = cost stage.
interface cost_stream_if #(
  parameter int p     = 4,
  parameter int width = 12,
  parameter int ew    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [p-1:0][width-1:0]   a;
  logic [p-1:0]              y;
  logic                      out_valid;
  logic                      out_ready;
  logic [p-1:0][width-1:0]   c;
  logic                      out_last;
  logic [ew-1:0]             err_sum;

  modport master (
    output in_valid, a, y, out_ready,
    input  in_ready, out_valid, c, out_last, err_sum
  );

  modport slave (
    input  in_valid, a, y, out_ready,
    output in_ready, out_valid, c, out_last, err_sum
  );
endinterface

// File: rtl/cost_lane.sv
// One neuron lane: c = sat(a - (y ? 1.0 : 0)) and |c| for the error sum.
// Ports: a (signed activation), y (ideal output bit), c (saturated cost term),
//        mag (|c|, with the most negative value clamped to the positive limit).
module cost_lane
  import cost_pkg::*;
#(
  parameter int width    = 12,
  parameter int int_bits = 3
) (
  input  logic signed [width-1:0] a,
  input  logic                    y,
  output logic signed [width-1:0] c,
  output logic        [width-1:0] mag
);
  localparam logic signed [width:0]   ONE_X  = (width+1)'(one(width, int_bits));
  localparam logic signed [width:0]   MAX_X  = (width+1)'(sat_max(width));
  localparam logic signed [width:0]   MIN_X  = (width+1)'(sat_min(width));
  localparam logic signed [width-1:0] MAX_W  = width'(sat_max(width));
  localparam logic signed [width-1:0] MIN_W  = width'(sat_min(width));

  function automatic logic signed [width-1:0] sat(input logic signed [width:0] v);
    if (v > MAX_X)      return MAX_W;
    else if (v < MIN_X) return MIN_W;
    else                return v[width-1:0];
  endfunction

  function automatic logic [width-1:0] abs_clamp(input logic signed [width-1:0] v);
    logic signed [width-1:0] neg;
    neg = -v;
    if (v == MIN_W)   return MAX_W;
    else if (v < 0)   return neg;
    else              return v;
  endfunction

  logic signed [width:0] diff;

  // One guard bit keeps the subtraction exact before clamping.
  assign diff = $signed({a[width-1], a}) - (y ? ONE_X : '0);
  assign c    = sat(diff);
  assign mag  = abs_clamp(c);

endmodule

// File: rtl/cost_stream.sv
// Streaming output-layer delta: c[k] = sat(a[k] - y[k]) for p lanes per beat,
// registered valid/ready output, beat position tracking and last-beat flag.
// Ports: clk, reset_n (async active-low), flush (sync sample abort),
//        s (cost_stream_if.slave: input beat, output beat, err_sum).
// Build option: define COST_ERRSUM_EN to accumulate the per-sample L1 error on
// err_sum; without it err_sum is constant 0.
module cost_stream
  import cost_pkg::*;
#(
  parameter int z        = 16,
  parameter int p        = 4,
  parameter int width    = 12,
  parameter int int_bits = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  cost_stream_if.slave s
);
  localparam int NBEAT = z / p;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int EW    = err_width(width, z);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  logic [p-1:0][width-1:0] lane_c;
  logic [p-1:0][width-1:0] lane_mag;
  logic                    in_rdy;
  logic                    accept;
  logic                    is_last;
  logic [BW-1:0]           beat;
  logic [p-1:0][width-1:0] c_p0;
  logic                    last_p0;
  logic                    vld_p0;
  logic [EW-1:0]           err_sum_p0;

  for (genvar k = 0; k < p; k++) begin : g_lane
    cost_lane #(.width(width), .int_bits(int_bits)) u_lane (
      .a   (s.a[k]),
      .y   (s.y[k]),
      .c   (lane_c[k]),
      .mag (lane_mag[k])
    );
  end

  // flush wins over any handshake in the same cycle.
  assign in_rdy  = !flush && (!vld_p0 || s.out_ready);
  assign accept  = s.in_valid && in_rdy;
  assign is_last = (beat == LAST_BEAT);

  // ---- stage p0: registered output beat ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      c_p0    <= '0;
      beat    <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      beat    <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      c_p0    <= lane_c;
      last_p0 <= is_last;
      beat    <= is_last ? '0 : beat + 1'b1;
    end else if (s.out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

`ifdef COST_ERRSUM_EN
  logic [EW-1:0] beat_sum;
  logic [EW-1:0] acc;

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < p; k++) beat_sum = beat_sum + EW'(lane_mag[k]);
  end

  // The last beat's own sum is folded in directly so err_sum lines up with
  // the last output beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      err_sum_p0 <= '0;
    end else if (flush) begin
      acc        <= '0;
      err_sum_p0 <= '0;
    end else if (accept) begin
      if (is_last) begin
        err_sum_p0 <= acc + beat_sum;
        acc        <= '0;
      end else begin
        acc        <= acc + beat_sum;
      end
    end
  end
`else
  logic unused_mag;
  assign unused_mag = ^lane_mag;
  assign err_sum_p0 = '0;
`endif

  assign s.in_ready  = in_rdy;
  assign s.out_valid = vld_p0;
  assign s.c         = c_p0;
  assign s.out_last  = last_p0;
  assign s.err_sum   = err_sum_p0;

endmodule

// File: tb/tb_cost_stream.sv
module tb_cost_stream;
  localparam int Z     = 16;
  localparam int P     = 4;
  localparam int W     = 12;
  localparam int IB    = 3;
  localparam int NB    = Z / P;
  localparam int EW    = W + $clog2(Z);
  localparam int ONE_M = 1 << (W - IB - 1);
  localparam int MAXV  = (1 << (W - 1)) - 1;
  localparam int MINV  = -(1 << (W - 1));

  typedef struct {
    logic [P*W-1:0] c;
    bit             last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  exp_t q[$];
  int   beat_m = 0;
  int   acc_m = 0;
  int   es_m = 0;

  always #5 clk = ~clk;

  cost_stream_if #(.p(P), .width(W), .ew(EW)) bus ();

  cost_stream #(.z(Z), .p(P), .width(W), .int_bits(IB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .s       (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    beat_m = 0;
    acc_m  = 0;
    es_m   = 0;
  endtask

  // Reference: plain integer arithmetic on the real-valued rule c = a - y.
  task automatic model_accept(input logic [P*W-1:0] av, input logic [P-1:0] yv);
    exp_t e;
    int   sum;
    sum = 0;
    for (int k = 0; k < P; k++) begin
      int v;
      v = $signed(av[k*W +: W]);
      v = v - (yv[k] ? ONE_M : 0);
      if (v > MAXV) v = MAXV;
      if (v < MINV) v = MINV;
      e.c[k*W +: W] = W'(v);
      sum += (v < 0) ? ((-v > MAXV) ? MAXV : -v) : v;
    end
    e.last = (beat_m == NB - 1);
`ifdef COST_ERRSUM_EN
    if (e.last) begin
      es_m  = acc_m + sum;
      acc_m = 0;
    end else begin
      acc_m = acc_m + sum;
    end
`endif
    beat_m = e.last ? 0 : beat_m + 1;
    q.push_back(e);
  endtask

  // One clock: drive at edge+1, check at negedge, advance model after edge.
  task automatic step(input bit iv, input bit ordy, input bit fl,
                      input logic [P*W-1:0] av, input logic [P-1:0] yv);
    bit er;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.a         = av;
    bus.y         = yv;
    flush         = fl;
    @(negedge clk);
    er = !fl && (q.size() == 0 || ordy);
    check("in_ready", 64'(bus.in_ready), 64'(er));
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("c", 64'(bus.c), 64'(q[0].c));
      check("out_last", 64'(bus.out_last), 64'(q[0].last));
    end
    check("err_sum", 64'(bus.err_sum), 64'(es_m));
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && er) model_accept(av, yv);
    end
    #1;
  endtask

  function automatic logic [P*W-1:0] rand_a();
    logic [P*W-1:0] r;
    for (int k = 0; k < P; k++) begin
      case ($urandom_range(0, 5))
        0:       r[k*W +: W] = 12'h800;
        1:       r[k*W +: W] = 12'h7FF;
        2:       r[k*W +: W] = 12'h100;
        default: r[k*W +: W] = W'($urandom);
      endcase
    end
    return r;
  endfunction

  logic [P*W-1:0] tv_a;
  logic [P*W-1:0] hold_a;
  logic [P-1:0]   hold_y;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.y         = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_c", 64'(bus.c), 64'd0);
    check("rst_err_sum", 64'(bus.err_sum), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;

    // reference vector as first beat, then three zero beats to close the sample
    tv_a = {12'h100, 12'h0F0, 12'h040, 12'h000};
    step(1, 1, 0, tv_a, 4'b1101);
    check("tv_c", 64'(bus.c), 64'({12'h000, 12'hFF0, 12'h040, 12'hF00}));
    step(1, 1, 0, '0, '0);
    step(1, 1, 0, '0, '0);
    step(1, 1, 0, '0, '0);
    check("tv_last", 64'(bus.out_last), 64'd1);
`ifdef COST_ERRSUM_EN
    check("tv_err_sum", 64'(bus.err_sum), 64'h150);
`else
    check("tv_err_sum", 64'(bus.err_sum), 64'h0);
`endif

    // saturation at both ends
    step(1, 1, 0, {12'h000, 12'h000, 12'h7FF, 12'h800}, 4'b0001);
    check("sat_c", 64'(bus.c), 64'({12'h000, 12'h000, 12'h7FF, 12'h800}));

    // finish that sample plus two back-to-back random samples
    for (int i = 0; i < 3 + 2 * NB; i++) step(1, 1, 0, rand_a(), 4'($urandom));

    // backpressure: out_ready low for 3 cycles with a beat waiting
    step(1, 0, 0, rand_a(), 4'($urandom));
    hold_a = rand_a();
    hold_y = 4'($urandom);
    for (int i = 0; i < 3; i++) step(1, 0, 0, hold_a, hold_y);
    step(1, 1, 0, hold_a, hold_y);
    step(0, 1, 0, '0, '0);

    // flush on beat 2 of a sample
    step(1, 1, 0, rand_a(), 4'($urandom));
    step(1, 1, 0, rand_a(), 4'($urandom));
    step(1, 1, 1, rand_a(), 4'($urandom));
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < NB; i++) step(1, 1, 0, rand_a(), 4'($urandom));

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, rand_a(), 4'($urandom));
    step(0, 1, 0, '0, '0);

    // asynchronous reset between edges, mid-sample
    step(1, 1, 0, rand_a(), 4'($urandom));
    step(1, 1, 0, rand_a(), 4'($urandom));
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_last", 64'(bus.out_last), 64'd0);
    check("arst_c", 64'(bus.c), 64'd0);
    check("arst_err_sum", 64'(bus.err_sum), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < NB; i++) step(1, 1, 0, rand_a(), 4'($urandom));
    check("arst_last4", 64'(bus.out_last), 64'd1);
    step(0, 1, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cost_stream.md
# cost_stream

Streaming, parametrised successor to the combinational cost-term set. Accepts the network's output activations `p` neurons per beat, computes the per-neuron output-layer delta `c = a - y` with saturation, and delivers it downstream over a registered valid/ready interface. It tracks beat position within a `z`-neuron sample, flags the last beat, and optionally accumulates the sample's L1 error. It sits between the final forward-pass layer and the backprop delta path.

## Interface
- `z`, 16: neurons per sample; must be a multiple of `p`
- `p`, 4: lanes (neurons) per beat
- `width`, 12: fixed-point word width, two's complement
- `int_bits`, 3: integer bits excluding sign; frac bits `f = width-int_bits-1` (defaults: 1.0 = 0x100)
- `clk` in 1: clock
- `reset_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous abort of the current sample
- `in_valid` in 1: input beat valid
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`
- `a` in `p`×`width` signed: computed activations, lane 0 = lowest neuron index of the beat
- `y` in `p`: ideal outputs, bit k for lane k (0 or 1.0)
- `out_valid` out 1: output beat valid
- `out_ready` in 1: downstream accepts
- `c` out `p`×`width` signed: cost terms
- `out_last` out 1: output beat is the final beat of the sample
- `err_sum` out `width+$clog2(z)` unsigned: sample L1 error, valid when `out_valid && out_last` (only with `COST_ERRSUM_EN`)

## Operation
- Per lane: `c[k] = sat(a[k] - (y[k] ? 1<<f : 0))`, computed at `width+1` bits, clamped to [`-2^(width-1)`, `2^(width-1)-1`].
- Single registered output stage; `in_ready = !flush && (!out_valid || out_ready)`.
- Beat counter `beat` in 0..`z/p-1` advances on each accepted input; wraps to 0 after `z/p-1`. `out_last` registers `beat == z/p-1` of the accepted beat.
- `out_valid` sets on input acceptance, clears on `out_ready` without new acceptance; simultaneous drain and accept keeps it high with new data.
- `c`, `out_last` hold while `out_valid && !out_ready`.
- `flush`: clears `beat`, the accumulator and `out_valid`; takes priority over any same-cycle handshake (input not accepted, pending output dropped).
- Degenerate `z == p`: every beat is last.

## Timing
- Latency 1 cycle: beat accepted at edge n appears on `c` after edge n.
- Throughput one beat per cycle while `out_ready` is high.
- Reset (async assert, sync deassert from the driver): `out_valid=0`, `out_last=0`, `c` all 0, `err_sum=0`, `beat=0`, accumulator 0. Reset mid-sample discards partial state.

## Configuration
- `COST_ERRSUM_EN` defined: per beat, `sum_k |c[k]|` (|`-2^(width-1)`| clamped to `2^(width-1)-1`) added to the accumulator on acceptance; on the last beat `err_sum` is loaded with accumulator + that beat's sum and the accumulator clears; `err_sum` holds until the next last beat or flush/reset.
- Undefined: no accumulator logic; `err_sum` tied to 0.

## Structure
- Shared package `cost_pkg`: fixed-point `one(width,int_bits)` constant function, saturation limits, `err_width(width,z)` function.
- One sub-module `cost_lane` (combinational subtract, saturate, abs), instantiated `p` times; counter, handshake and accumulator in the top.

## Test plan
- z=4,p=4, a={000,040,0F0,100}, y=4'b1101, out_ready=1 -> c={F00,040,FF0,000}, out_last=1 one cycle later, err_sum=0x150.
- Saturation: a[0]=0x800,y[0]=1; a[1]=0x7FF,y[1]=0 -> c[0]=0x800, c[1]=0x7FF; err_sum lane terms 0x7FF each.
- z=16,p=4, four back-to-back beats -> out_last only on 4th, beat counter wraps, second sample's err_sum independent of first.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, c/out_last stable, no beat lost or duplicated after release.
- flush asserted with in_valid=1 on beat 2 of 4 -> beat not accepted, out_valid=0 next cycle, next beat treated as beat 0, accumulator restarted.
- reset_n pulsed mid-sample (asynchronous, between edges) -> all outputs 0 immediately; next sample's out_last on its 4th beat.
